pc_flag_unit: RTL and testbench
===============================

# pc_flag_unit

Sequential front end of the next-PC path: holds the program counter and the N/Z/V status register that the jump/branch control stage consumes, and registers the next-PC value that stage produces. Provides `pc` and `pc4` to fetch and branch logic. Inserts wait cycles when a memory-indirect target (bmn, jmor, jalm, jspal) is not yet valid. Supports a halt state and a bounded memory-wait timeout.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0080, PC loaded on timeout (and on misalignment when enabled).
- `WAIT_MAX`, 15, maximum stall cycles waiting for `mem_ready`; counter width = clog2(WAIT_MAX+1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next_pc`  in  32  target chosen by jump/branch control (already pc4 when no branch).
- `br_enable`  in  1  jump/branch control reports an active branch/jump this cycle.
- `mem_ind`  in  1  current target is memory-indirect (from `mem_out`).
- `mem_ready`  in  1  data memory output valid this cycle.
- `flag_we`  in  1  current instruction updates status flags.
- `n_in`, `z_in`, `v_in`  in  1 each  ALU flags.
- `halt`  in  1  halt request (decoded halt instruction).
- `pc`  out  32  current PC (registered).
- `pc4`  out  32  `pc + 4` (combinational, mod 2^32).
- `n`, `z`, `v`  out  1 each  registered status flags.
- `stall`  out  1  high while in WAIT; fetch/register-file writes must hold.
- `halted`  out  1  high in HALT.
- `trap`  out  1  one-cycle pulse on the cycle the trap vector is loaded.

## Operation
- States: RUN, WAIT, HALT. Reset → RUN, `pc`=RESET_PC, `n`=`z`=`v`=0, wait counter 0, `stall`=`halted`=`trap`=0.
- RUN:
  - `halt`=1 → HALT; `pc` unchanged.
  - Else if `br_enable & mem_ind & ~mem_ready` → WAIT; `pc` unchanged; counter cleared.
  - Else → `pc` <= `next_pc`.
- WAIT:
  - `stall`=1.
  - `mem_ready`=1 → `pc` <= `next_pc`; → RUN.
  - Counter reaching WAIT_MAX without ready → `pc` <= TRAP_VECTOR, `trap` pulse; → RUN.
  - Counter increments each WAIT cycle and saturates (no wrap).
  - `halt` ignored in WAIT.
- HALT: `pc` and flags frozen; exit only by reset.
- Flags: `flag_we`=1 in RUN loads {n,z,v} <= {n_in,z_in,v_in} on the same edge as the PC update. `flag_we` is ignored in WAIT and HALT, so flags never change mid-stall.
- Priority in RUN: halt > wait-entry > normal update.
- `pc4` wraps: `pc`=32'hFFFF_FFFC gives `pc4`=0.

## Timing
- One-cycle latency: `next_pc` sampled at edge k, visible on `pc` after edge k.
- Flags are visible to the branch stage in the cycle after the flag-setting instruction (no same-cycle forwarding).
- `mem_ready` is sampled only while in WAIT or at the RUN entry decision; `mem_ready` high in the entry cycle means no stall.
- Maximum stall: WAIT_MAX cycles, then the trap edge.
- Reset asserted mid-WAIT or in HALT returns all outputs to reset values immediately (asynchronous).

## Configuration
- `PC_ALIGN_CHK_EN` defined:
  - A PC load with `next_pc[1:0]` != 0 loads TRAP_VECTOR instead and pulses `trap`.
  - Applies in RUN and on WAIT completion.
- Not defined: no alignment check; `next_pc` is loaded verbatim and `trap` fires only on timeout.

## Structure
- Shared package holds the state encoding (RUN=2'd0, WAIT=2'd1, HALT=2'd2), the default RESET_PC/TRAP_VECTOR constants, and the flag-vector index constants N/Z/V.
- One sub-module: `wait_timer`, the saturating counter with clear/enable and a `expired` output.

## Test plan
- Reset: `rst_n` low → `pc`=0, flags 0, `stall`=0. Release with `next_pc`=4 → `pc`=4 after one edge.
- Indirect stall: `br_enable`=`mem_ind`=1, `mem_ready`=0 for 3 cycles, then 1 with `next_pc`=32'h100 → `stall` high 3 cycles, then `pc`=32'h100.
- Timeout: same as above but `mem_ready` never rises → after 15 WAIT cycles `pc`=32'h80, `trap` pulses once.
- Flags: `flag_we`=1 with `n_in`=1, `z_in`=0 → `n`=1 next cycle; `flag_we` asserted during WAIT → flags unchanged.
- Halt: `halt`=1 at `pc`=32'h20 → `halted`=1 and `pc` stays 32'h20 for 10 cycles; async reset mid-halt → `pc`=0.
- Misalignment (`PC_ALIGN_CHK_EN`): `next_pc`=32'h102 → `pc`=32'h80, `trap`=1. Without the macro → `pc`=32'h102.

Source files
------------

// File: rtl/pc_flag_unit_pkg.sv
// Shared definitions for the next-PC / status-flag front end.
// Holds the control state encoding, default reset/trap addresses and the
// bit positions of N/Z/V inside the packed flag vector.
package pc_flag_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0080;

   // Flag vector layout: {n, z, v}
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/pc_flag_unit_wait_timer.sv
// wait_timer: saturating stall-cycle counter for the memory-indirect wait.
// Ports: clk, rst_n (async active-low), clr (synchronous clear, wins over en),
//        en (count one cycle), expired (this enabled cycle is the MAX-th one).
module wait_timer #(
   parameter int MAX = 15,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);
   localparam logic [W-1:0] TOP  = W'(MAX);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != TOP)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Counter holds the number of already-completed wait cycles, so the
   // cycle in which it reads MAX-1 is the one whose closing edge reaches MAX.
   assign expired = en && (cnt >= LAST);

endmodule

// File: rtl/pc_flag_unit.sv
// pc_flag_unit: program counter and N/Z/V status register feeding the branch stage.
// Ports: clk, rst_n (async active-low); next_pc, br_enable, mem_ind, mem_ready,
//        flag_we, n_in/z_in/v_in, halt in; pc, pc4, n/z/v, stall, halted, trap out.
// Optional macro PC_ALIGN_CHK_EN: misaligned next_pc loads redirect to the trap vector.
module pc_flag_unit
   import pc_flag_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
   parameter int          WAIT_MAX    = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        br_enable,
   input  logic        mem_ind,
   input  logic        mem_ready,
   input  logic        flag_we,
   input  logic        n_in,
   input  logic        z_in,
   input  logic        v_in,
   input  logic        halt,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        n,
   output logic        z,
   output logic        v,
   output logic        stall,
   output logic        halted,
   output logic        trap
);

   localparam int WAIT_W = $clog2(WAIT_MAX + 1);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  flags_q, flags_d;
   logic        trap_q, trap_d;
   logic        timer_clr, timer_en, timer_expired;
   logic [31:0] load_pc;
   logic        load_trap;

   wait_timer #(
      .MAX (WAIT_MAX),
      .W   (WAIT_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   // Value a normal PC load would take, including the optional alignment redirect.
   always_comb begin
      load_pc   = next_pc;
      load_trap = 1'b0;
`ifdef PC_ALIGN_CHK_EN
      if (next_pc[1:0] != 2'b00) begin
         load_pc   = TRAP_VECTOR;
         load_trap = 1'b1;
      end
`else
`endif
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      flags_d   = flags_q;
      trap_d    = 1'b0;
      timer_clr = 1'b0;
      timer_en  = 1'b0;
      case (state_q)
         ST_RUN: begin
            timer_clr = 1'b1;
            if (halt) begin
               state_d = ST_HALT;
            end else if (br_enable && mem_ind && !mem_ready) begin
               // Indirect target not available yet: hold PC, flags wait too.
               state_d = ST_WAIT;
            end else begin
               pc_d   = load_pc;
               trap_d = load_trap;
               if (flag_we) begin
                  flags_d[FLAG_N] = n_in;
                  flags_d[FLAG_Z] = z_in;
                  flags_d[FLAG_V] = v_in;
               end
            end
         end
         ST_WAIT: begin
            timer_en = 1'b1;
            // Data arriving on the last allowed cycle still beats the timeout.
            if (mem_ready) begin
               pc_d    = load_pc;
               trap_d  = load_trap;
               state_d = ST_RUN;
            end else if (timer_expired) begin
               pc_d    = TRAP_VECTOR;
               trap_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         flags_q <= 3'b000;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
         trap_q  <= trap_d;
      end
   end

   assign pc     = pc_q;
   assign pc4    = pc_q + 32'd4;
   assign n      = flags_q[FLAG_N];
   assign z      = flags_q[FLAG_Z];
   assign v      = flags_q[FLAG_V];
   assign stall  = (state_q == ST_WAIT);
   assign halted = (state_q == ST_HALT);
   assign trap   = trap_q;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Self-checking bench for pc_flag_unit: vector table, hand-written corner
// sequences (stall, timeout, halt, async reset, alignment) and a randomized
// run against a cycle-level behavioural model.
module tb_pc_flag_unit;

   localparam logic [31:0] TRAP = 32'h0000_0080;
   localparam int          WMAX = 15;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        br_enable, mem_ind, mem_ready, flag_we;
   logic        n_in, z_in, v_in, halt;
   logic [31:0] pc, pc4;
   logic        n, z, v, stall, halted, trap;

   int total = 0;
   int bad   = 0;

   pc_flag_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .next_pc   (next_pc),
      .br_enable (br_enable),
      .mem_ind   (mem_ind),
      .mem_ready (mem_ready),
      .flag_we   (flag_we),
      .n_in      (n_in),
      .z_in      (z_in),
      .v_in      (v_in),
      .halt      (halt),
      .pc        (pc),
      .pc4       (pc4),
      .n         (n),
      .z         (z),
      .v         (v),
      .stall     (stall),
      .halted    (halted),
      .trap      (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;
   logic [2:0]  m_nzv;
   bit          m_halted, m_waiting, m_trap;
   int          m_waited;

   function automatic bit misaligned(input logic [31:0] a);
`ifdef PC_ALIGN_CHK_EN
      return (a % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_nzv = 3'b000; m_halted = 0; m_waiting = 0; m_trap = 0; m_waited = 0;
   endtask

   task automatic model_load(input logic [31:0] a);
      if (misaligned(a)) begin
         m_pc = TRAP; m_trap = 1;
      end else begin
         m_pc = a;
      end
   endtask

   task automatic model_edge();
      m_trap = 0;
      if (m_halted) begin
         // frozen until reset
      end else if (m_waiting) begin
         m_waited = m_waited + 1;
         if (mem_ready) begin
            model_load(next_pc); m_waiting = 0;
         end else if (m_waited == WMAX) begin
            m_pc = TRAP; m_trap = 1; m_waiting = 0;
         end
      end else if (halt) begin
         m_halted = 1;
      end else if (br_enable && mem_ind && !mem_ready) begin
         m_waiting = 1; m_waited = 0;
      end else begin
         model_load(next_pc);
         if (flag_we) m_nzv = {n_in, z_in, v_in};
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic [31:0] np, input logic b, input logic mi, input logic mr,
                        input logic fw, input logic [2:0] f, input logic h);
      next_pc = np; br_enable = b; mem_ind = mi; mem_ready = mr;
      flag_we = fw; {n_in, z_in, v_in} = f; halt = h;
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_pc", pc, 32'h0);
      chk("arst_halted", {31'b0, halted}, 32'h0);
      chk("arst_stall", {31'b0, stall}, 32'h0);
      chk("arst_flags", {29'b0, n, z, v}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [31:0] np;
      logic        b, mi, mr, fw;
      logic [2:0]  f;
      logic        h;
      logic [31:0] exp_pc;
      logic [2:0]  exp_f;
      logic        exp_stall;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [31:0] exp_mis;
      logic        exp_mtrap;

      tbl[0] = '{32'h0000_0004, 0, 0, 0, 0, 3'b000, 0, 32'h0000_0004, 3'b000, 0};
      tbl[1] = '{32'h0000_0008, 0, 0, 0, 1, 3'b100, 0, 32'h0000_0008, 3'b100, 0};
      tbl[2] = '{32'h0000_000C, 0, 0, 0, 1, 3'b011, 0, 32'h0000_000C, 3'b011, 0};
      tbl[3] = '{32'h0000_0040, 1, 1, 1, 0, 3'b000, 0, 32'h0000_0040, 3'b011, 0};
      tbl[4] = '{32'h0000_0100, 1, 1, 0, 0, 3'b000, 0, 32'h0000_0040, 3'b011, 1};
      tbl[5] = '{32'h0000_0100, 1, 1, 0, 1, 3'b100, 1, 32'h0000_0040, 3'b011, 1};
      tbl[6] = '{32'h0000_0100, 1, 1, 0, 1, 3'b100, 0, 32'h0000_0040, 3'b011, 1};
      tbl[7] = '{32'h0000_0100, 1, 1, 1, 0, 3'b000, 0, 32'h0000_0100, 3'b011, 0};
      tbl[8] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 3'b000, 0, 32'hFFFF_FFFC, 3'b011, 0};
      tbl[9] = '{32'h0000_0000, 0, 0, 0, 1, 3'b000, 0, 32'h0000_0000, 3'b000, 0};

      // ---- reset ----
      rst_n = 1'b0;
      drive(32'h0, 0, 0, 0, 0, 3'b000, 0);
      model_reset();
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_flags", {29'b0, n, z, v}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_trap", {30'b0, trap, halted}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- vector table ----
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].np, tbl[i].b, tbl[i].mi, tbl[i].mr, tbl[i].fw, tbl[i].f, tbl[i].h);
         step();
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
         chk($sformatf("tbl%0d_pc4", i), pc4, tbl[i].exp_pc + 32'd4);
         chk($sformatf("tbl%0d_flags", i), {29'b0, n, z, v}, {29'b0, tbl[i].exp_f});
         chk($sformatf("tbl%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].exp_stall});
         chk($sformatf("tbl%0d_trap", i), {31'b0, trap}, 32'h0);
      end

      // ---- timeout: 15 WAIT cycles then trap ----
      drive(32'h0000_0200, 1, 1, 0, 0, 3'b000, 0);
      step();
      chk("to_enter_stall", {31'b0, stall}, 32'h1);
      for (int i = 1; i < WMAX; i++) begin
         drive(32'h0000_0200, 1, 1, 0, 1, 3'b111, 1);
         step();
         chk($sformatf("to_wait%0d", i), {30'b0, stall, trap}, 32'h2);
      end
      step();
      chk("to_pc", pc, TRAP);
      chk("to_trap", {31'b0, trap}, 32'h1);
      chk("to_stall", {31'b0, stall}, 32'h0);
      chk("to_flags", {29'b0, n, z, v}, 32'h0);
      drive(32'h0000_0084, 0, 0, 0, 0, 3'b000, 0);
      step();
      chk("to_trap_once", {31'b0, trap}, 32'h0);
      chk("to_after_pc", pc, 32'h0000_0084);

      // ---- halt at 0x20, frozen for 10 cycles, async reset mid-halt ----
      drive(32'h0000_0020, 0, 0, 0, 0, 3'b000, 0);
      step();
      drive(32'h0000_0024, 0, 0, 0, 0, 3'b000, 1);
      step();
      for (int i = 0; i < 10; i++) begin
         drive($urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), 1'($urandom), 1, 3'b111, 1'($urandom));
         step();
         chk($sformatf("halt%0d_pc", i), pc, 32'h0000_0020);
         chk($sformatf("halt%0d_st", i), {29'b0, halted, n, z}, 32'h4);
      end
      async_reset();

      // ---- misalignment in RUN and on WAIT completion ----
`ifdef PC_ALIGN_CHK_EN
      exp_mis = TRAP; exp_mtrap = 1'b1;
`else
      exp_mis = 32'h0000_0102; exp_mtrap = 1'b0;
`endif
      drive(32'h0000_0102, 0, 0, 0, 0, 3'b000, 0);
      step();
      chk("mis_run_pc", pc, exp_mis);
      chk("mis_run_trap", {31'b0, trap}, {31'b0, exp_mtrap});
      drive(32'h0000_0300, 1, 1, 0, 0, 3'b000, 0);
      step();
      drive(32'h0000_0102, 1, 1, 1, 0, 3'b000, 0);
      step();
      chk("mis_wait_pc", pc, exp_mis);
      chk("mis_wait_trap", {31'b0, trap}, {31'b0, exp_mtrap});

      // ---- randomized run against the model ----
      async_reset();
      begin
         int halt_cycles = 0;
         for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 8 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                  1'($urandom), 1'($urandom), ($urandom % 8) == 0,
                  1'($urandom), 3'($urandom), ($urandom % 250) == 0);
            step();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pc4", pc4, m_pc + 32'd4);
            chk("rnd_flags", {29'b0, n, z, v}, {29'b0, m_nzv});
            chk("rnd_ctl", {29'b0, stall, halted, trap}, {29'b0, m_waiting, m_halted, m_trap});
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4) begin
               async_reset();
               halt_cycles = 0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
